matmul_engine: RTL

- Downstream consumer of the MMIO/SRAM memory map; owns memory port B.
- Polls MATMUL_Flag. When the flag is set, it loads the matmul config registers, computes C = A x B (signed, row-major) from SRAM, writes C back to SRAM, then clears the flag.
- Single MAC, sequential. Lets the host offload matrix multiply without per-element firmware.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_mac.sv | 39 +++
 rtl/matmul_engine.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: memory-map addresses, FSM state encoding and config fetch order shared by matmul_engine.
package matmul_pkg;
  localparam logic [11:0] MATMUL_A_IN_ADDR  = 12'h000;
  localparam logic [11:0] MATMUL_B_IN_ADDR  = 12'h100;
  localparam logic [11:0] MATMUL_C_OUT_ADDR = 12'h200;
  localparam logic [11:0] MATMUL_DIM_M_ADDR = 12'h600;
  localparam logic [11:0] MATMUL_DIM_N_ADDR = 12'h700;
  localparam logic [11:0] MATMUL_DIM_P_ADDR = 12'h800;
  localparam logic [11:0] MATMUL_FLAG_ADDR  = 12'hA00;

  typedef enum logic [3:0] {IDLE, POLL, LD_CFG, RD_A, RD_B, MAC, WR_C, CLR, DONE} state_e;

  function automatic logic [11:0] cfg_addr(input logic [2:0] idx);
    return idx == 3'd0 ? MATMUL_A_IN_ADDR  :
           idx == 3'd1 ? MATMUL_B_IN_ADDR  :
           idx == 3'd2 ? MATMUL_C_OUT_ADDR :
           idx == 3'd3 ? MATMUL_DIM_M_ADDR :
           idx == 3'd4 ? MATMUL_DIM_N_ADDR :
           idx == 3'd5 ? MATMUL_DIM_P_ADDR : 12'h000;
  endfunction
endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: signed multiply-accumulate with clear and enable.
// Result wraps to DATA_WIDTH, or saturates when MATMUL_SAT_EN is defined.
module matmul_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);
  logic [2*DATA_WIDTH-1:0] a_x, b_x, prod;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;

  always_comb begin
    a_x   = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    b_x   = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    prod  = a_x * b_x;
    acc_d = clr ? '0 :
            en  ? acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod} : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;

`ifdef MATMUL_SAT_EN
  // In range exactly when every bit above the result sign bit matches it.
  logic [ACC_WIDTH-DATA_WIDTH:0] hi;
  assign hi     = acc_q[ACC_WIDTH-1:DATA_WIDTH-1];
  assign result = (&hi || ~|hi) ? acc_q[DATA_WIDTH-1:0] :
                  {acc_q[ACC_WIDTH-1], {(DATA_WIDTH-1){~acc_q[ACC_WIDTH-1]}}};
`else
  assign result = acc_q[DATA_WIDTH-1:0];
`endif
endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: polls MATMUL_Flag, computes C = A x B from SRAM over port B, then clears the flag.
// Define MATMUL_SAT_EN to saturate each C element to the signed DATA_WIDTH range.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 12,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DIM_WIDTH-1:0]  dim_t;

  state_e                state_q, state_d;
  logic [2:0]            cfg_idx_q, cfg_idx_d;
  addr_t                 a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  addr_t                 a_row_q, a_row_d, a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d;
  dim_t                  m_q, m_d, n_q, n_d, p_q, p_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DATA_WIDTH-1:0] a_op_q, a_op_d, result;
  addr_t                 mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  addr_t                 rd_addr;
  dim_t                  rd_dim;

  assign rd_addr = ADDR_WIDTH'(mem_rdata);
  assign rd_dim  = DIM_WIDTH'(mem_rdata);

  matmul_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == LD_CFG || state_q == WR_C),
    .en     (state_q == MAC),
    .a      (a_op_q),
    .b      (mem_rdata),
    .result (result)
  );

  // Port-B outputs are registered: the address chosen in a state is on the port the following cycle,
  // which is exactly the cycle whose end samples mem_rdata.
  always_comb begin
    state_d     = state_q;
    cfg_idx_d   = cfg_idx_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    c_base_d    = c_base_q;
    a_row_d     = a_row_q;
    a_ptr_d     = a_ptr_q;
    b_ptr_d     = b_ptr_q;
    c_ptr_d     = c_ptr_q;
    m_d         = m_q;
    n_d         = n_q;
    p_d         = p_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    a_op_d      = a_op_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        mem_addr_d = ADDR_WIDTH'(MATMUL_FLAG_ADDR);
        state_d    = POLL;
      end
      POLL: begin
        cfg_idx_d = '0;
        state_d   = |mem_rdata ? LD_CFG : IDLE;
      end
      LD_CFG: begin
        mem_addr_d = cfg_idx_q < 3'd6 ? ADDR_WIDTH'(cfg_addr(cfg_idx_q)) : '0;
        cfg_idx_d  = cfg_idx_q + 3'd1;
        a_base_d   = cfg_idx_q == 3'd1 ? rd_addr : a_base_q;
        b_base_d   = cfg_idx_q == 3'd2 ? rd_addr : b_base_q;
        c_base_d   = cfg_idx_q == 3'd3 ? rd_addr : c_base_q;
        m_d        = cfg_idx_q == 3'd4 ? rd_dim  : m_q;
        n_d        = cfg_idx_q == 3'd5 ? rd_dim  : n_q;
        p_d        = cfg_idx_q == 3'd6 ? rd_dim  : p_q;
        if (cfg_idx_q == 3'd6) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          a_row_d = a_base_q;
          a_ptr_d = a_base_q;
          b_ptr_d = b_base_q;
          c_ptr_d = c_base_q;
          state_d = (m_q == '0 || n_q == '0 || rd_dim == '0) ? CLR : RD_A;
        end
      end
      RD_A: begin
        mem_addr_d = a_ptr_q;
        state_d    = RD_B;
      end
      RD_B: begin
        mem_addr_d = b_ptr_q;
        a_op_d     = mem_rdata;
        state_d    = MAC;
      end
      MAC: if (k_q == n_q - DIM_WIDTH'(1)) state_d = WR_C;
      else begin
        k_d     = k_q + DIM_WIDTH'(1);
        a_ptr_d = a_ptr_q + ADDR_WIDTH'(1);
        b_ptr_d = b_ptr_q + ADDR_WIDTH'(p_q);
        state_d = RD_A;
      end
      WR_C: begin
        mem_addr_d  = c_ptr_q;
        mem_wdata_d = result;
        mem_we_d    = 1'b1;
        c_ptr_d     = c_ptr_q + ADDR_WIDTH'(1);
        k_d         = '0;
        state_d     = RD_A;
        if (j_q < p_q - DIM_WIDTH'(1)) begin
          j_d     = j_q + DIM_WIDTH'(1);
          a_ptr_d = a_row_q;
          b_ptr_d = b_base_q + ADDR_WIDTH'(j_q) + ADDR_WIDTH'(1);
        end else begin
          j_d     = '0;
          b_ptr_d = b_base_q;
          if (i_q == m_q - DIM_WIDTH'(1)) state_d = CLR;
          else begin
            i_d     = i_q + DIM_WIDTH'(1);
            a_row_d = a_row_q + ADDR_WIDTH'(n_q);
            a_ptr_d = a_row_q + ADDR_WIDTH'(n_q);
          end
        end
      end
      CLR: begin
        mem_addr_d = ADDR_WIDTH'(MATMUL_FLAG_ADDR);
        mem_we_d   = 1'b1;
        state_d    = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_idx_q   <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      a_row_q     <= '0;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      c_ptr_q     <= '0;
      m_q         <= '0;
      n_q         <= '0;
      p_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      a_op_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_idx_q   <= cfg_idx_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      c_base_q    <= c_base_d;
      a_row_q     <= a_row_d;
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      c_ptr_q     <= c_ptr_d;
      m_q         <= m_d;
      n_q         <= n_d;
      p_q         <= p_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      a_op_q      <= a_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = !(state_q inside {IDLE, POLL});
  assign done      = state_q == DONE;
endmodule
